// File: rtl/bin_to_bcd_pkg.sv
// Shared display definitions for the binary-to-BCD converter and the digit decoders.
package bin_to_bcd_pkg;

    // Code the 7-segment decoder renders as all segments off.
    localparam logic [3:0] BLANK_DIGIT = 4'hF;

    localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
    localparam logic [1:0] ST_SHIFT_ENC  = 2'd1;
    localparam logic [1:0] ST_FINISH_ENC = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = ST_IDLE_ENC,
        ST_SHIFT  = ST_SHIFT_ENC,
        ST_FINISH = ST_FINISH_ENC
    } state_t;

endpackage

// File: rtl/bin_to_bcd_seq_add3.sv
// Double-dabble digit cell: a BCD digit of 5 or more gets 3 added before the shift.
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // The digit is at most 9 here, so the 4-bit result never wraps.
    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock,
// with leading-zero blanked digits for the 7-segment display layer.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | waiting for start; result registers hold the last conversion
// ST_SHIFT  | one add-3 + shift per clock, cnt counts remaining input bits
// ST_FINISH | publish bcd_out/bcd_blank/overflow and pulse done
module bin_to_bcd_seq
    import bin_to_bcd_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [4*DIGITS-1:0]   bcd_blank,
    output logic                  overflow
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int BCD_W = 4 * DIGITS;
    localparam logic [BCD_W-1:0] BLANK_RESET = {{(DIGITS-1){BLANK_DIGIT}}, 4'h0};

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIN_W-1:0]   bin_work_q, bin_work_d;
    logic [BCD_W-1:0]   bcd_work_q, bcd_work_d;
    logic               ovf_work_q, ovf_work_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [BCD_W-1:0]   bcd_out_q, bcd_out_d;
    logic [BCD_W-1:0]   bcd_blank_q, bcd_blank_d;
    logic               overflow_q, overflow_d;

    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   blank_calc;
    logic               lead_zero;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (bcd_work_q[4*g +: 4]),
            .dout (bcd_adj[4*g +: 4])
        );
    end

    // Leading zeros above digit 0 are blanked until the first non-zero digit.
    always_comb begin
        blank_calc = bcd_work_q;
        lead_zero  = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (lead_zero && (bcd_work_q[4*i +: 4] == 4'h0)) begin
                blank_calc[4*i +: 4] = BLANK_DIGIT;
            end else begin
                lead_zero = 1'b0;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bin_work_d  = bin_work_q;
        bcd_work_d  = bcd_work_q;
        ovf_work_d  = ovf_work_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        bcd_out_d   = bcd_out_q;
        bcd_blank_d = bcd_blank_q;
        overflow_d  = overflow_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    bin_work_d = bin_in;
                    bcd_work_d = '0;
                    ovf_work_d = 1'b0;
                    cnt_d      = CNT_W'(BIN_W);
                    busy_d     = 1'b1;
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // A bit leaving the top digit means the value needs more than DIGITS digits.
                bcd_work_d = {bcd_adj[BCD_W-2:0], bin_work_q[BIN_W-1]};
                bin_work_d = {bin_work_q[BIN_W-2:0], 1'b0};
                ovf_work_d = ovf_work_q | bcd_adj[BCD_W-1];
                cnt_d      = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                bcd_out_d   = bcd_work_q;
                bcd_blank_d = blank_calc;
                overflow_d  = ovf_work_q;
                done_d      = 1'b1;
                busy_d      = 1'b0;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bin_work_q  <= '0;
            bcd_work_q  <= '0;
            ovf_work_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            bcd_out_q   <= '0;
            bcd_blank_q <= BLANK_RESET;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bin_work_q  <= bin_work_d;
            bcd_work_q  <= bcd_work_d;
            ovf_work_q  <= ovf_work_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            bcd_out_q   <= bcd_out_d;
            bcd_blank_q <= bcd_blank_d;
            overflow_q  <= overflow_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign bcd_out   = bcd_out_q;
    assign bcd_blank = bcd_blank_q;
    assign overflow  = overflow_q;

endmodule
